// File: rtl/seg7_bin2bcd.sv
// Iterative shift-add-3 binary-to-BCD converter with leading-zero blanking for the 7-seg decoders.
// Latency WIDTH cycles from accepted start to oDONE; starts arriving while busy are dropped, not queued.
module seg7_bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iSTART,
  input  logic [WIDTH-1:0]      iBIN,
  input  logic                  iBLANK_EN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oDIG,
  output logic [DIGITS-1:0]     oON
);

  localparam int BCD_W      = 4 * DIGITS;
  localparam int SR_W       = BCD_W + WIDTH;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  // floor(WIDTH*log10(2))+1 is the decimal digit count of 2^WIDTH-1
  localparam int MIN_DIGITS = (WIDTH * 30103) / 100000 + 1;

  generate
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("seg7_bin2bcd: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [SR_W-1:0]     r_sr, w_sr_nxt, w_add, w_shift;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_blank, w_blank_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [BCD_W-1:0]    r_dig, w_dig_nxt, w_new_dig;
  logic [DIGITS-1:0]   r_on, w_on_nxt, w_new_on;
  logic                w_seen;

  always_comb begin
    w_add = r_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_sr[WIDTH+4*i +: 4] >= 4'd5)
        w_add[WIDTH+4*i +: 4] = r_sr[WIDTH+4*i +: 4] + 4'd3;
    end
    w_shift   = {w_add[SR_W-2:0], 1'b0};
    w_new_dig = w_shift[SR_W-1 -: BCD_W];
  end

  // A digit stays lit once any digit at or above it is non-zero; units always lit.
  always_comb begin
    w_seen   = 1'b0;
    w_new_on = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_new_dig[4*i +: 4] != 4'd0)
        w_seen = 1'b1;
      w_new_on[i] = !r_blank || w_seen || (i == 0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_blank_nxt = r_blank;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_dig_nxt   = r_dig;
    w_on_nxt    = r_on;
    case (r_state)
      S_IDLE: begin
        if (iSTART) begin
          w_sr_nxt    = {{BCD_W{1'b0}}, iBIN};
          w_blank_nxt = iBLANK_EN;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sr_nxt  = w_shift;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_dig_nxt   = w_new_dig;
          w_on_nxt    = w_new_on;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_blank <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dig   <= '0;
      r_on    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blank <= w_blank_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dig   <= w_dig_nxt;
      r_on    <= w_on_nxt;
    end
  end

  assign oBUSY = r_busy;
  assign oDONE = r_done;
  assign oDIG  = r_dig;
  assign oON   = r_on;

endmodule

// File: tb/tb_seg7_bin2bcd.sv
// Bench for seg7_bin2bcd: directed scenarios plus random values against a divide/modulo decimal model.
module tb_seg7_bin2bcd;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iSTART;
  logic [15:0] iBIN;
  logic        iBLANK_EN;
  logic        oBUSY;
  logic        oDONE;
  logic [19:0] oDIG;
  logic [4:0]  oON;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seg7_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iBIN(iBIN),
    .iBLANK_EN(iBLANK_EN), .oBUSY(oBUSY), .oDONE(oDONE), .oDIG(oDIG), .oON(oON)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [19:0] ref_dig(input int unsigned v);
    logic [19:0] d;
    int unsigned x;
    d = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      d[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return d;
  endfunction

  function automatic logic [4:0] ref_on(input int unsigned v, input logic blank);
    int nd;
    int unsigned x;
    if (!blank) return 5'b11111;
    nd = 1;
    x = v / 10;
    while (x != 0) begin
      nd++;
      x = x / 10;
    end
    return 5'((1 << nd) - 1);
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the oDONE edge (or timeout).
  task automatic run_conv(input logic [15:0] v, input logic b, output int lat,
                          output int busy_cyc, output logic [19:0] d, output logic [4:0] o);
    iSTART = 1'b1; iBIN = v; iBLANK_EN = b;
    @(posedge iCLK); #1;
    iSTART = 1'b0; iBIN = $urandom; iBLANK_EN = $urandom;
    busy_cyc = oBUSY ? 1 : 0;
    lat = -1; d = 'x; o = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge iCLK); #1;
      if (oBUSY) busy_cyc++;
      if (oDONE) begin
        lat = n; d = oDIG; o = oON;
        break;
      end
    end
  endtask

  task automatic test_reset;
    iRST_N = 1'b0; iSTART = 1'b1; iBIN = 16'd999; iBLANK_EN = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    total_cnt++; if (oBUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", oBUSY); else pass_cnt++;
    total_cnt++; if (oDONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", oDONE); else pass_cnt++;
    total_cnt++; if (oDIG !== 20'h0) $display("FAIL reset_dig got=%h exp=00000", oDIG); else pass_cnt++;
    total_cnt++; if (oON !== 5'b0) $display("FAIL reset_on got=%b exp=00000", oON); else pass_cnt++;
    iRST_N = 1'b1;
    @(posedge iCLK); #1;
  endtask

  task automatic test_zero;
    int lat, bc; logic [19:0] d; logic [4:0] o;
    run_conv(16'd0, 1'b1, lat, bc, d, o);
    total_cnt++; if (lat !== 16) $display("FAIL zero_latency got=%0d exp=16", lat); else pass_cnt++;
    total_cnt++; if (d !== 20'h00000) $display("FAIL zero_dig got=%h exp=00000", d); else pass_cnt++;
    total_cnt++; if (o !== 5'b00001) $display("FAIL zero_on got=%b exp=00001", o); else pass_cnt++;
    @(posedge iCLK); #1;
    total_cnt++; if (oDONE !== 1'b0) $display("FAIL zero_done_pulse got=%b exp=0", oDONE); else pass_cnt++;
    total_cnt++; if (oON !== 5'b00001) $display("FAIL zero_on_hold got=%b exp=00001", oON); else pass_cnt++;
  endtask

  task automatic test_max;
    int lat, bc; logic [19:0] d; logic [4:0] o;
    run_conv(16'd65535, 1'b1, lat, bc, d, o);
    total_cnt++; if (lat !== 16) $display("FAIL max_latency got=%0d exp=16", lat); else pass_cnt++;
    total_cnt++; if (bc !== 16) $display("FAIL max_busy_cycles got=%0d exp=16", bc); else pass_cnt++;
    total_cnt++; if (oBUSY !== 1'b0) $display("FAIL max_busy_in_done got=%b exp=0", oBUSY); else pass_cnt++;
    total_cnt++; if (d !== ref_dig(65535)) $display("FAIL max_dig got=%h exp=%h", d, ref_dig(65535)); else pass_cnt++;
    total_cnt++; if (o !== ref_on(65535, 1'b1)) $display("FAIL max_on got=%b exp=%b", o, ref_on(65535, 1'b1)); else pass_cnt++;
  endtask

  task automatic test_blanking;
    int lat, bc; logic [19:0] d; logic [4:0] o;
    for (int b = 1; b >= 0; b--) begin
      run_conv(16'd1234, 1'(b), lat, bc, d, o);
      total_cnt++; if (d !== 20'h01234) $display("FAIL blank%0d_dig got=%h exp=01234", b, d); else pass_cnt++;
      total_cnt++; if (o !== ref_on(1234, 1'(b))) $display("FAIL blank%0d_on got=%b exp=%b", b, o, ref_on(1234, 1'(b))); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_busy;
    int dones; logic [19:0] d; logic [4:0] o;
    iSTART = 1'b1; iBIN = 16'd7; iBLANK_EN = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    dones = 0; d = 'x; o = 'x;
    for (int n = 1; n <= 40; n++) begin
      iSTART    = (n >= 3 && n <= 10);
      iBIN      = 16'd9999;
      iBLANK_EN = 1'b0;
      @(posedge iCLK); #1;
      if (oDONE) begin
        dones++; d = oDIG; o = oON;
      end
    end
    iSTART = 1'b0;
    total_cnt++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d exp=1", dones); else pass_cnt++;
    total_cnt++; if (d !== 20'h00007) $display("FAIL ignore_dig got=%h exp=00007", d); else pass_cnt++;
    total_cnt++; if (o !== 5'b00001) $display("FAIL ignore_on got=%b exp=00001", o); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int t[2]; logic [19:0] d[2]; logic [4:0] o[2]; int seen;
    iSTART = 1'b1; iBIN = 16'd100; iBLANK_EN = 1'b1;
    @(posedge iCLK); #1;
    iBIN = 16'd42;
    seen = 0; t[0] = -100; t[1] = 0;
    for (int n = 1; n <= 60 && seen < 2; n++) begin
      @(posedge iCLK); #1;
      if (oDONE) begin
        t[seen] = n; d[seen] = oDIG; o[seen] = oON;
        seen++;
      end
    end
    iSTART = 1'b0;
    total_cnt++; if (seen !== 2) $display("FAIL b2b_done_count got=%0d exp=2", seen); else pass_cnt++;
    total_cnt++; if (t[1] - t[0] !== 17) $display("FAIL b2b_spacing got=%0d exp=17", t[1] - t[0]); else pass_cnt++;
    total_cnt++; if (d[0] !== 20'h00100) $display("FAIL b2b_dig0 got=%h exp=00100", d[0]); else pass_cnt++;
    total_cnt++; if (o[0] !== 5'b00111) $display("FAIL b2b_on0 got=%b exp=00111", o[0]); else pass_cnt++;
    total_cnt++; if (d[1] !== 20'h00042) $display("FAIL b2b_dig1 got=%h exp=00042", d[1]); else pass_cnt++;
    total_cnt++; if (o[1] !== 5'b00011) $display("FAIL b2b_on1 got=%b exp=00011", o[1]); else pass_cnt++;
    @(posedge iCLK); #1;
  endtask

  task automatic test_reset_abort;
    int dones, lat, bc; logic [19:0] d; logic [4:0] o;
    iSTART = 1'b1; iBIN = 16'd12345; iBLANK_EN = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (7) @(posedge iCLK);
    #1;
    iRST_N = 1'b0;
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    total_cnt++; if (oBUSY !== 1'b0) $display("FAIL abort_busy got=%b exp=0", oBUSY); else pass_cnt++;
    total_cnt++; if (oDIG !== 20'h0) $display("FAIL abort_dig got=%h exp=00000", oDIG); else pass_cnt++;
    total_cnt++; if (oON !== 5'b0) $display("FAIL abort_on got=%b exp=00000", oON); else pass_cnt++;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge iCLK); #1;
      if (oDONE) dones++;
    end
    total_cnt++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else pass_cnt++;
    run_conv(16'd12345, 1'b1, lat, bc, d, o);
    total_cnt++; if (lat !== 16) $display("FAIL abort_restart_latency got=%0d exp=16", lat); else pass_cnt++;
    total_cnt++; if (d !== 20'h12345) $display("FAIL abort_restart_dig got=%h exp=12345", d); else pass_cnt++;
    total_cnt++; if (o !== 5'b11111) $display("FAIL abort_restart_on got=%b exp=11111", o); else pass_cnt++;
  endtask

  task automatic test_random;
    int lat, bc; logic [19:0] d; logic [4:0] o;
    logic [15:0] v; logic b;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 9));
        1:       v = 16'($urandom_range(0, 999));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      b = 1'($urandom);
      run_conv(v, b, lat, bc, d, o);
      total_cnt++; if (lat !== 16) $display("FAIL rnd_latency v=%0d got=%0d exp=16", v, lat); else pass_cnt++;
      total_cnt++; if (d !== ref_dig(v)) $display("FAIL rnd_dig v=%0d got=%h exp=%h", v, d, ref_dig(v)); else pass_cnt++;
      total_cnt++; if (o !== ref_on(v, b)) $display("FAIL rnd_on v=%0d b=%b got=%b exp=%b", v, b, o, ref_on(v, b)); else pass_cnt++;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge iCLK); #1;
      end
    end
  endtask

  initial begin
    iRST_N = 1'b0; iSTART = 1'b0; iBIN = '0; iBLANK_EN = 1'b0;
    test_reset();
    test_zero();
    test_max();
    test_blanking();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_bin2bcd.md
# seg7_bin2bcd

Sequential binary-to-BCD converter with leading-zero blanking. It sits directly upstream of the bank of 7-segment LUT decoders. It converts an unsigned binary value into DIGITS packed BCD nibbles using an iterative shift-add-3 method. It also produces one display-enable bit per digit, which drives the decoders' ON_OFF input. Results stay stable between conversions, so the decoders and pins never see intermediate values.

## Interface
- WIDTH, 16, bit width of the unsigned binary input.
- DIGITS, 5, number of BCD digits produced. Must be at least the decimal digit count of 2^WIDTH-1. Elaboration must fail otherwise.
- iCLK  input  1  single clock; all state changes on the rising edge.
- iRST_N  input  1  reset, synchronous and active-low.
- iSTART  input  1  conversion request, sampled only in IDLE.
- iBIN  input  WIDTH  binary value, captured on the accepted iSTART edge.
- iBLANK_EN  input  1  leading-zero blanking enable, captured with iBIN.
- oBUSY  output  1  high while a conversion is in progress.
- oDONE  output  1  one-cycle pulse when new results are presented.
- oDIG  output  4*DIGITS  packed BCD; digit i occupies [4i+3:4i], digit 0 is the units digit.
- oON  output  DIGITS  per-digit enable for the decoder ON_OFF input; 1 means lit.

## Operation
- State machine with two states, IDLE and SHIFT.
- IDLE, with iSTART=1 on an edge:
  - load the shift register with the BCD field cleared and the binary field = iBIN;
  - capture iBLANK_EN, clear the bit counter, go to SHIFT, set oBUSY=1.
- SHIFT, each edge:
  - every BCD nibble >= 5 first gets +3 (all nibbles in parallel, 4-bit add, no carry between nibbles);
  - then the whole {BCD, binary} register shifts left by 1;
  - the counter increments.
- After the WIDTH-th shift edge:
  - oDIG is loaded from the BCD field and oON is computed;
  - oDONE=1 for one cycle, oBUSY=0, state returns to IDLE.
- iSTART in SHIFT is ignored; it is not queued. iBIN and iBLANK_EN changes during SHIFT have no effect.
- Blanking rule, when blanking was captured as 1:
  - oON[i]=0 if digit i and every higher digit are 0;
  - exception: oON[0] is always 1, so a value of 0 shows a single "0".
- With blanking captured as 0, oON is all ones.
- oDIG always carries the true BCD digits, including blanked zeros.
- oDIG and oON change only on the edge that raises oDONE.

## Timing
- Reset values (iRST_N=0 sampled on an edge):
  - state IDLE; oBUSY=0, oDONE=0;
  - oDIG all zeros, oON all zeros (display dark until the first conversion);
  - internal shift register and counter cleared.
- Reset mid-conversion aborts it: no oDONE and outputs go to reset values. Reset takes priority over iSTART on the same edge.
- Latency: iSTART accepted at edge k means:
  - oBUSY=1 from edge k;
  - new oDIG/oON and oDONE=1 from edge k+WIDTH;
  - oDONE=0 again from edge k+WIDTH+1.
  - Default latency is 16 cycles.
- Throughput: state is IDLE during the oDONE cycle, so iSTART high in that cycle is accepted at edge k+WIDTH+1. This gives one conversion per WIDTH+1 cycles, 17 by default.
- oBUSY is low in the oDONE cycle.
- Combinational depth per cycle is one add-3 stage per nibble plus the shift. No multi-cycle paths.

## Test plan
- Reset, then iBIN=16'd0, iBLANK_EN=1, iSTART pulse -> oDONE exactly 16 cycles after the start edge; oDIG=20'h00000, oON=5'b00001.
- iBIN=16'd65535, iBLANK_EN=1 -> oDIG=20'h65535, oON=5'b11111, oBUSY high for exactly 16 cycles.
- iBIN=16'd1234, iBLANK_EN=1 -> oDIG=20'h01234, oON=5'b01111. Repeat with iBLANK_EN=0 -> oON=5'b11111, same oDIG.
- iBIN=16'd7, blanking on, then iSTART pulses and iBIN=9999 while oBUSY=1 -> ignored; the result is oDIG=20'h00007, oON=5'b00001, and only one oDONE.
- Back-to-back: iSTART held high continuously with iBIN=100, then 42 -> oDONE pulses 17 cycles apart; oDIG=20'h00100 then 20'h00042; oON=5'b00111 then 5'b00011.
- iRST_N=0 at the 8th SHIFT cycle after loading 12345 -> no oDONE; oDIG=0, oON=0, oBUSY=0. A new start after release converts correctly.
